div_sequencer: RTL and testbench

DIV_SEQUENCER -- requirements
Module: div_sequencer

---
 rtl/div_sequencer_pkg.sv | 19 +
 rtl/div_step.sv | 24 ++
 rtl/div_sequencer.sv | 117 +++++++++++
 tb/tb_div_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared CPU package: divider FSM encoding, iteration count and divide-by-zero constants.
package div_sequencer_pkg;

  // Divider sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    ON   = 2'd2,
    DONE = 2'd3
  } divState_t;

  // Number of shift-subtract iterations for a full-width divide
  localparam int DIV_CYCLES = 32;

  // Divide-by-zero result: quotient is every bit set, remainder is the dividend
  localparam logic DIV_ZERO_QUOT_BIT = 1'b1;
  localparam logic [DIV_CYCLES-1:0] DIV_ZERO_QUOTIENT = {DIV_CYCLES{DIV_ZERO_QUOT_BIT}};

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             dvdBit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             qBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift the next dividend bit in; keep the difference only if it did not borrow.
  // remIn < divisor always, so the restored value fits back into WIDTH bits.
  assign shifted = {remIn, dvdBit};
  assign diff    = shifted - {1'b0, divisor};
  assign qBit    = ~diff[WIDTH];
  assign remOut  = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer: accepts a request from E, iterates one bit per
// cycle, applies the sign fix-up and presents {remainder, quotient} for one cycle.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               stall,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  divState_t          stateReg;
  logic [CW-1:0]      countReg;
  logic [WIDTH-1:0]   opaReg;
  logic [WIDTH-1:0]   opbReg;
  logic               signedReg;
  logic [WIDTH-1:0]   dvdReg;
  logic [WIDTH-1:0]   remReg;
  logic [2*WIDTH-1:0] resultReg;

  logic             accept;
  logic             negA;
  logic             negB;
  logic [WIDTH-1:0] opaMag;
  logic [WIDTH-1:0] divisorMag;
  logic [WIDTH-1:0] remNext;
  logic             qBit;
  logic [WIDTH-1:0] quotRaw;
  logic [WIDTH-1:0] quotFix;
  logic [WIDTH-1:0] remFix;

  assign accept = (stateReg == IDLE) & start & ~annul;

  // Magnitude of the incoming dividend, loaded straight into the shift register
  assign opaMag = (signed_div & opa[WIDTH-1]) ? -opa : opa;

  // Sign information of the latched operands drives divisor magnitude and fix-up
  assign negA       = signedReg & opaReg[WIDTH-1];
  assign negB       = signedReg & opbReg[WIDTH-1];
  assign divisorMag = negB ? -opbReg : opbReg;

  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn   (remReg),
    .dvdBit  (dvdReg[WIDTH-1]),
    .divisor (divisorMag),
    .remOut  (remNext),
    .qBit    (qBit)
  );

  // Quotient bits shift in behind the consumed dividend bits
  assign quotRaw = {dvdReg[WIDTH-2:0], qBit};
  assign quotFix = (negA ^ negB) ? -quotRaw : quotRaw;
  assign remFix  = negA ? -remNext : remNext;

  // Pipeline hold and result strobe; an annul drops both immediately, and stall is
  // forced low while reset is asserted even if start is already up.
  assign stall  = rst & ~annul & (accept | (stateReg == ZERO) | (stateReg == ON));
  assign ready  = ~annul & (stateReg == DONE);
  assign result = resultReg;

  // FSM, iteration counter, operand latches and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg  <= IDLE;
      countReg  <= '0;
      opaReg    <= '0;
      opbReg    <= '0;
      signedReg <= 1'b0;
      dvdReg    <= '0;
      remReg    <= '0;
      resultReg <= '0;
    end else if (annul) begin
      stateReg <= IDLE;
      countReg <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (start) begin
            opaReg    <= opa;
            opbReg    <= opb;
            signedReg <= signed_div;
            dvdReg    <= opaMag;
            remReg    <= '0;
            countReg  <= '0;
            stateReg  <= (opb == '0) ? ZERO : ON;
          end
        end
        ZERO: begin
          resultReg <= {opaReg, {WIDTH{DIV_ZERO_QUOT_BIT}}};
          stateReg  <= DONE;
        end
        ON: begin
          remReg   <= remNext;
          dvdReg   <= quotRaw;
          countReg <= countReg + CW'(1);
          if (countReg == CW'(WIDTH - 1)) begin
            resultReg <= {remFix, quotFix};
            stateReg  <= DONE;
          end
        end
        DONE: stateReg <= IDLE;
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed + light random bench for div_sequencer with a result scoreboard.
module tb_div_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         signed_div = 1'b0;
  logic         annul = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         stall;
  logic         ready;
  logic [2*W-1:0] result;

  logic [63:0] sbq[$];
  int checks = 0;
  int errors = 0;

  div_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opa        (opa),
    .opb        (opb),
    .stall      (stall),
    .ready      (ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the outputs of the current cycle; inputs were set at the preceding negedge
  task automatic tick(input string tag, input bit eStall, input bit eReady);
    logic [63:0] exp;
    #1;
    check({tag, " stall"}, 64'(stall), 64'(eStall));
    check({tag, " ready"}, 64'(ready), 64'(eReady));
    if (ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s result observed=%h expected=none", tag, result);
      end else begin
        exp = sbq.pop_front();
        check({tag, " result"}, result, exp);
      end
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    int sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a; sb = b;
      q = sa / sb;
      r = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Full divide: start held through DONE (ignored there), dropped afterwards
  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input bit sgn, input logic [63:0] exp);
    int lat;
    lat = (b == 0) ? 2 : 33;
    sbq.push_back(exp);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      start = 1'b1;
      signed_div = (c == 0) ? sgn : ~sgn;
      opa = (c == 0) ? a : $urandom;
      opb = (c == 0) ? b : $urandom;
      tick(tag, c < lat, c == lat);
    end
    @(negedge clk);
    start = 1'b0;
    tick({tag, " idle"}, 1'b0, 1'b0);
    $display("txn %s a=%h b=%h signed=%0d expected=%h got=%h", tag, a, b, sgn, exp, result);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;

    // Reset state, with start already raised
    start = 1'b1;
    @(negedge clk);
    tick("reset", 1'b0, 1'b0);
    check("reset result", result, 64'h0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    tick("post reset", 1'b0, 1'b0);
    $display("txn reset");

    runOp("udiv 100/7", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E});
    runOp("sdiv -7/2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    runOp("div by zero", 32'h1234_5678, 32'h0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF});
    runOp("sdiv overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000});
    runOp("sdiv 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
    runOp("udiv max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF});
    runOp("udiv small/big", 32'd5, 32'hFFFF_FFFF, 1'b0, {32'd5, 32'h0});

    // Annul in cycle 10, restart in cycle 11, completion in cycle 44
    for (int c = 0; c <= 44; c++) begin
      @(negedge clk);
      start = 1'b1;
      annul = (c == 10);
      signed_div = 1'b0;
      if (c == 0) begin opa = 32'd1000; opb = 32'd3; end
      if (c == 11) begin opa = 32'd500; opb = 32'd7; sbq.push_back({32'd3, 32'd71}); end
      tick("annul on", (c != 10) && (c != 44), c == 44);
    end
    @(negedge clk);
    start = 1'b0;
    tick("annul on idle", 1'b0, 1'b0);
    $display("txn annul-in-ON then 500/7");

    // Annul in DONE of a zero-divisor op suppresses ready
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      start = (c < 2);
      annul = (c == 2);
      opa = 32'd5; opb = 32'd0;
      tick("annul done", c < 2, 1'b0);
    end
    annul = 1'b0;
    $display("txn annul-in-DONE");

    // start together with annul in IDLE is not accepted
    @(negedge clk);
    start = 1'b1; annul = 1'b1; opa = 32'd9; opb = 32'd3;
    tick("annul idle", 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    tick("annul idle next", 1'b0, 1'b0);
    $display("txn annul-in-IDLE");

    // Reset in cycle 20 of a divide, then a clean divide
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b1; signed_div = 1'b0; opa = 32'd77; opb = 32'd5;
      if (c == 20) rst = 1'b0;
      tick("mid reset", c < 20, 1'b0);
    end
    check("mid reset result", result, 64'h0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    tick("mid reset release", 1'b0, 1'b0);
    $display("txn reset-mid-divide");
    runOp("after reset 100/7", 32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E});

    // A few random operand pairs against the reference model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      rs = 1'($urandom_range(0, 1));
      if (i == 5) rb = 32'h0;
      runOp($sformatf("random %0d", i), ra, rb, rs, model(ra, rb, rs));
    end

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard drain observed=%0d expected=0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
